// File: rtl/get_legendre_segment_div_pkg.sv
// rtl/get_legendre_segment_div_pkg.sv - shared widths, saturation limits and FSM states for the segment divider
// Purpose: default operand widths, signed quotient limits and the state type
//          used by get_legendre_segment_div and its unsigned core.
// Ports:   none (package).
package get_legendre_segment_div_pkg;

  localparam int DIVIDEND_W_C = 35;
  localparam int DIVISOR_W_C  = 18;
  localparam int QUOT_W_C     = 18;

  localparam int QMAX = (1 << (QUOT_W_C - 1)) - 1;
  localparam int QMIN = -(1 << (QUOT_W_C - 1));

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

endpackage

// File: rtl/get_legendre_segment_udiv_core.sv
// rtl/get_legendre_segment_udiv_core.sv - radix-2 restoring unsigned shift-subtract datapath
// Purpose: produces one quotient bit per step, MSB first, from unsigned magnitudes.
// Ports:   clk, rst_n         clock, asynchronous active-low reset
//          load_i             capture magnitudes, clear partial remainder, arm counter
//          step_i             perform one shift/compare/subtract iteration
//          dividend_i         dividend magnitude
//          divisor_i          divisor magnitude
//          last_o             current step is the final iteration
//          quot_o, rem_o      raw magnitude quotient and final remainder
module get_legendre_segment_udiv_core #(
  parameter int DIVIDEND_W = 35,
  parameter int DIVISOR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  last_o,
  output logic [DIVIDEND_W-1:0] quot_o,
  output logic [DIVISOR_W-1:0]  rem_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  // dq_q starts holding the dividend; each step shifts a dividend bit out of
  // the top and a quotient bit into the bottom, so it ends as the quotient.
  logic [DIVIDEND_W-1:0] dq_q, dq_d;
  logic [DIVISOR_W-1:0]  prem_q, prem_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // The stored remainder is always below the divisor, so only the trial
  // value needs the extra bit.
  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] diff;
  logic               ge;

  always_comb begin
    trial  = {prem_q, dq_q[DIVIDEND_W-1]};
    diff   = trial - {1'b0, dvsr_q};
    ge     = (trial >= {1'b0, dvsr_q});
    dq_d   = dq_q;
    prem_d = prem_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      dq_d   = dividend_i;
      prem_d = '0;
      dvsr_d = divisor_i;
      cnt_d  = CNT_W'(DIVIDEND_W - 1);
    end else if (step_i) begin
      prem_d = ge ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
      dq_d   = {dq_q[DIVIDEND_W-2:0], ge};
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_q   <= '0;
      prem_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else begin
      dq_q   <= dq_d;
      prem_q <= prem_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign last_o = (cnt_q == '0);
  assign quot_o = dq_q;
  assign rem_o  = prem_q;

endmodule

// File: rtl/get_legendre_segment_div.sv
// rtl/get_legendre_segment_div.sv - iterative signed divider with ap_* block handshake
// Purpose: signed 35/18 division, quotient truncated toward zero and saturated
//          to 18 bits, remainder signed like the dividend, fixed latency.
// Ports:   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//          ap_start/ap_ready         request / operand-accept pulse (IDLE only)
//          ap_idle, ap_done          idle level / result-valid pulse
//          dividend, divisor         signed operands, captured on accept
//          quotient, remainder       signed results, held until next done
//          div_by_zero, overflow     status of the last result
module get_legendre_segment_div
  import get_legendre_segment_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_C,
  parameter int DIVISOR_W  = DIVISOR_W_C,
  parameter int QUOT_W     = QUOT_W_C
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_ready,
  output logic                        ap_idle,
  output logic                        ap_done,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic signed [QUOT_W-1:0]     quotient,
  output logic signed [DIVISOR_W-1:0]  remainder,
  output logic                        div_by_zero,
  output logic                        overflow
);

  // Magnitude thresholds for saturation: a negative result may reach
  // 2^(QUOT_W-1) exactly, a positive one only 2^(QUOT_W-1)-1.
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(1) << (QUOT_W - 1);
  localparam logic [DIVIDEND_W-1:0] POS_LIM = NEG_LIM - 1'b1;
  localparam logic [QUOT_W-1:0]     QMAX_L  = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     QMIN_L  = {1'b1, {(QUOT_W-1){1'b0}}};

  state_e state_q, state_d;

  logic qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic [QUOT_W-1:0]    quot_q, quot_d;
  logic [DIVISOR_W-1:0] rem_q, rem_d;
  logic                 dbz_q, dbz_d, ovf_q, ovf_d;

  logic                  load, step, core_last;
  logic [DIVIDEND_W-1:0] dvd_mag, core_quot;
  logic [DIVISOR_W-1:0]  dvs_mag, core_rem;

  // Two's-complement magnitudes; the most negative values still fit unsigned.
  assign dvd_mag = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = divisor[DIVISOR_W-1]   ? (~divisor + 1'b1)  : divisor;

  get_legendre_segment_udiv_core #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W)
  ) u_core (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (dvd_mag),
    .divisor_i  (dvs_mag),
    .last_o     (core_last),
    .quot_o     (core_quot),
    .rem_o      (core_rem)
  );

  always_comb begin
    state_d  = state_q;
    ap_ready = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      S_IDLE: if (ap_start) begin
        ap_ready = 1'b1;
        load     = 1'b1;
        state_d  = S_CALC;
      end
      S_CALC: begin
        step = 1'b1;
        if (core_last) state_d = S_FIX;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sign and zero-divisor decisions are taken at capture so later operand
  // changes cannot affect the result.
  always_comb begin
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    if (load) begin
      qneg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
      rneg_d = dividend[DIVIDEND_W-1];
      zero_d = (divisor == '0);
    end
  end

  // The divide-by-zero case still runs the core for constant latency; its
  // raw output is simply ignored here.
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    ovf_d  = ovf_q;
    if (state_q == S_FIX) begin
      dbz_d = zero_q;
      ovf_d = 1'b0;
      if (zero_q) begin
        quot_d = rneg_q ? QMIN_L : QMAX_L;
        rem_d  = '0;
      end else begin
        rem_d = rneg_q ? (~core_rem + 1'b1) : core_rem;
        if (!qneg_q) begin
          if (core_quot > POS_LIM) begin
            quot_d = QMAX_L;
            ovf_d  = 1'b1;
          end else begin
            quot_d = core_quot[QUOT_W-1:0];
          end
        end else if (core_quot > NEG_LIM) begin
          quot_d = QMIN_L;
          ovf_d  = 1'b1;
        end else begin
          quot_d = ~core_quot[QUOT_W-1:0] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ap_idle     = (state_q == S_IDLE);
  assign ap_done     = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_get_legendre_segment_div.sv
// tb/tb_get_legendre_segment_div.sv - self-checking bench for get_legendre_segment_div
module tb_get_legendre_segment_div;
  import get_legendre_segment_div_pkg::*;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic               ap_start = 1'b0;
  logic               ap_ready, ap_idle, ap_done;
  logic signed [34:0] dividend = '0;
  logic signed [17:0] divisor = '0;
  logic signed [17:0] quotient;
  logic signed [17:0] remainder;
  logic               div_by_zero, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  get_legendre_segment_div dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  // Reference: plain truncating integer division, then clamp to 18-bit signed.
  task automatic model(input longint a, input longint b,
                       output longint q, output longint r,
                       output longint dbz, output longint ovf);
    dbz = 0;
    ovf = 0;
    if (b == 0) begin
      dbz = 1;
      r   = 0;
      q   = (a >= 0) ? longint'(QMAX) : longint'(QMIN);
    end else begin
      q = a / b;
      r = a % b;
      if (q > QMAX) begin
        q = QMAX;
        ovf = 1;
      end else if (q < QMIN) begin
        q = QMIN;
        ovf = 1;
      end
    end
  endtask

  task automatic check_result(input string tag, input longint a, input longint b);
    longint q, r, dbz, ovf;
    model(a, b, q, r, dbz, ovf);
    check({tag, ".quot"}, longint'(quotient), q);
    check({tag, ".rem"}, longint'(remainder), r);
    check({tag, ".dbz"}, longint'(div_by_zero), dbz);
    check({tag, ".ovf"}, longint'(overflow), ovf);
  endtask

  task automatic run_op(input string tag, input longint a, input longint b);
    int lat;
    dividend = 35'(a);
    divisor  = 18'(b);
    ap_start = 1'b1;
    #1;
    check({tag, ".ready"}, longint'(ap_ready), 1);
    tick;
    ap_start = 1'b0;
    dividend = 35'($urandom());
    divisor  = 18'($urandom());
    lat = 1;
    while (!ap_done && lat < 60) begin
      tick;
      lat++;
    end
    check({tag, ".latency"}, lat, 37);
    check_result(tag, a, b);
    tick;
    check({tag, ".done_pulse"}, longint'(ap_done), 0);
    check({tag, ".idle_after"}, longint'(ap_idle), 1);
  endtask

  longint da[13] = '{1000, -1000, 1000, -1000, 3, -131072, 5, -5, 0,
                     64'sd1 << 30, -(64'sd1 << 34), -131072, 131072};
  longint db[13] = '{7, 7, -7, -7, 5, -131072, 0, 0, 0, 1, 1, 1, 1};

  longint qa[$];
  longint qb[$];
  int     acc_cnt, first_acc, saw_done;
  logic [34:0] rd;
  logic [17:0] rs;
  longint a, b;

  initial begin
    #1;
    check("reset.idle", longint'(ap_idle), 1);
    check("reset.ready", longint'(ap_ready), 0);
    check("reset.done", longint'(ap_done), 0);
    check("reset.quot", longint'(quotient), 0);
    check("reset.rem", longint'(remainder), 0);
    check("reset.dbz", longint'(div_by_zero), 0);
    check("reset.ovf", longint'(overflow), 0);
    tick;
    tick;
    ap_rst_n = 1'b1;
    tick;

    for (int i = 0; i < 13; i++) run_op($sformatf("dir%0d", i), da[i], db[i]);

    // Held start with operands changing every cycle.
    acc_cnt   = 0;
    first_acc = -1;
    for (int c = 0; c < 100; c++) begin
      dividend = 35'({$urandom(), $urandom()});
      divisor  = 18'($urandom());
      ap_start = 1'b1;
      #1;
      if (ap_ready) begin
        if (first_acc < 0) first_acc = c;
        check("hs.spacing", c, 38 * acc_cnt);
        acc_cnt++;
        qa.push_back(longint'(dividend));
        qb.push_back(longint'(divisor));
      end
      if (ap_done) begin
        check("hs.done_has_op", qa.size() > 0, 1);
        if (qa.size() > 0) check_result("hs", qa.pop_front(), qb.pop_front());
      end
      tick;
    end
    ap_start = 1'b0;
    for (int c = 0; c < 60 && qa.size() > 0; c++) begin
      if (ap_done) check_result("hs", qa.pop_front(), qb.pop_front());
      tick;
    end
    check("hs.first", first_acc, 0);
    check("hs.accepts", acc_cnt, 3);
    check("hs.pending", qa.size(), 0);
    while (!ap_idle) tick;

    // Reset during CALC, after a result that left nonzero outputs.
    run_op("pre_rst", 131072, 1);
    dividend = 35'(1000);
    divisor  = 18'(7);
    ap_start = 1'b1;
    #1;
    tick;
    ap_start = 1'b0;
    repeat (10) tick;
    check("rst.busy", longint'(ap_idle), 0);
    ap_rst_n = 1'b0;
    #1;
    check("rst.idle", longint'(ap_idle), 1);
    check("rst.done", longint'(ap_done), 0);
    check("rst.quot", longint'(quotient), 0);
    check("rst.rem", longint'(remainder), 0);
    check("rst.dbz", longint'(div_by_zero), 0);
    check("rst.ovf", longint'(overflow), 0);
    saw_done = 0;
    repeat (3) begin
      tick;
      if (ap_done) saw_done = 1;
    end
    ap_rst_n = 1'b1;
    repeat (40) begin
      tick;
      if (ap_done) saw_done = 1;
    end
    check("rst.no_done", saw_done, 0);
    run_op("post_rst", 1000, 7);

    // Random operands, mixed magnitudes, ~1% zero divisors.
    for (int i = 0; i < 1000; i++) begin
      rd = 35'({$urandom(), $urandom()});
      a  = longint'($signed(rd)) >>> $urandom_range(0, 34);
      rs = 18'($urandom());
      b  = longint'($signed(rs)) >>> $urandom_range(0, 16);
      if (b == 0) b = 1;
      if ($urandom_range(0, 99) == 0) b = 0;
      run_op("rand", a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
